// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan driver: segment bit positions,
// the hex glyph table and the scan FSM state encoding.
package seg7_pkg;

  // Segment bit positions inside a {G,F,E,D,C,B,A} vector.
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  typedef logic [SEG_G:SEG_A] seg7_t;

  // Active-high glyphs for 0..F (lower-case b and d keep them distinct from 8 and 0).
  localparam seg7_t SEG7_TABLE [0:15] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1100111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } state_t;

  function automatic seg7_t seg7_decode(input logic [3:0] nibble);
    return SEG7_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Bus between the value producer and the scan driver, plus the pin-facing outputs.
interface seg7_scan_driver_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   dp;
  logic                lz_blank;
  logic                load;
  logic                pending;
  logic                frame_start;
  logic [6:0]          seg;
  logic                dp_out;
  logic [DIGITS-1:0]   digit_en;

  modport master (
    output value, dp, lz_blank, load,
    input  pending, frame_start, seg, dp_out, digit_en
  );

  modport slave (
    input  value, dp, lz_blank, load,
    output pending, frame_start, seg, dp_out, digit_en
  );
endinterface

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-high {G..A} segment decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output seg7_t      o_seg
);

  assign o_seg = seg7_decode(i_nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver: double-buffered value, frame-aligned
// commit, per-digit dead time, leading-zero blanking, selectable polarity.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int ON_CYCLES      = 4000,
  parameter int BLANK_CYCLES   = 40,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b0
) (
  input logic clk,
  input logic reset,
  seg7_scan_driver_if.slave bus
);

  localparam int CNT_MAX = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t              r_state, w_state_next;
  logic [CNT_W-1:0]    r_cnt, w_cnt_next;
  logic [IDX_W-1:0]    r_idx, w_idx_next;

  logic [4*DIGITS-1:0] r_shadow_value, r_active_value;
  logic [DIGITS-1:0]   r_shadow_dp, r_active_dp;
  logic                r_shadow_lz, r_active_lz;
  logic                r_pending;

  logic                w_commit;
  seg7_t               w_dec [DIGITS];
  logic [DIGITS-1:0]   w_zero;
  logic [DIGITS-1:0]   w_blank;
  logic                w_show;
  seg7_t               w_seg_next;
  logic                w_dp_next;
  logic [DIGITS-1:0]   w_en_next;

  seg7_t               r_seg;
  logic                r_dp_out;
  logic [DIGITS-1:0]   r_digit_en;
  logic                r_frame_start;

  // The commit point is the very first blank cycle in front of digit 0.
  assign w_commit = (r_state == ST_BLANK) && (r_idx == '0) && (r_cnt == '0);

  // Scan state register; reset drops straight back into the digit-0 blank slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_BLANK;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
    end
  end

  // Slot sequencing: BLANK_CYCLES of dead time, then ON_CYCLES of drive, then next digit.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + 1'b1;
    w_idx_next   = r_idx;
    case (r_state)
      ST_BLANK: begin
        if (r_cnt == CNT_W'(BLANK_CYCLES - 1)) begin
          w_state_next = ST_ON;
          w_cnt_next   = '0;
        end
      end
      ST_ON: begin
        if (r_cnt == CNT_W'(ON_CYCLES - 1)) begin
          w_state_next = ST_BLANK;
          w_cnt_next   = '0;
          w_idx_next   = (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
        end
      end
    endcase
  end

  // Double buffer: loads land in the shadow; only the commit point updates active.
  // A load coinciding with the commit point bypasses the shadow entirely.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow_value <= '0;
      r_shadow_dp    <= '0;
      r_shadow_lz    <= 1'b0;
      r_active_value <= '0;
      r_active_dp    <= '0;
      r_active_lz    <= 1'b0;
      r_pending      <= 1'b0;
    end else begin
      if (bus.load) begin
        r_shadow_value <= bus.value;
        r_shadow_dp    <= bus.dp;
        r_shadow_lz    <= bus.lz_blank;
      end
      if (w_commit) begin
        if (bus.load) begin
          r_active_value <= bus.value;
          r_active_dp    <= bus.dp;
          r_active_lz    <= bus.lz_blank;
          r_pending      <= 1'b0;
        end else if (r_pending) begin
          r_active_value <= r_shadow_value;
          r_active_dp    <= r_shadow_dp;
          r_active_lz    <= r_shadow_lz;
          r_pending      <= 1'b0;
        end
      end else if (bus.load) begin
        r_pending <= 1'b1;
      end
    end
  end

  // One decoder per digit; the scan index then just selects a glyph.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    hex_to_seg7 u_dec (
      .i_nibble (r_active_value[4*gi +: 4]),
      .o_seg    (w_dec[gi])
    );
    assign w_zero[gi] = (r_active_value[4*gi +: 4] == 4'h0) && !r_active_dp[gi];
  end

  // Leading-zero run from the top digit down; a set dp breaks the run, digit 0 always shows.
  always_comb begin
    logic w_run;
    w_run   = 1'b1;
    w_blank = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      w_run      = w_run & w_zero[k];
      w_blank[k] = (k != 0) && r_active_lz && w_run;
    end
  end

  // Active-high output values for the current slot; blank slots and blanked digits stay dark.
  always_comb begin
    w_show     = (r_state == ST_ON) && !w_blank[r_idx];
    w_seg_next = w_show ? w_dec[r_idx] : '0;
    w_dp_next  = w_show && r_active_dp[r_idx];
    w_en_next  = w_show ? (DIGITS'(1) << r_idx) : '0;
  end

  // Output registers; polarity inversion is applied only here.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_seg         <= {7{SEG_ACTIVE_LOW}};
      r_dp_out      <= SEG_ACTIVE_LOW;
      r_digit_en    <= {DIGITS{DIG_ACTIVE_LOW}};
      r_frame_start <= 1'b0;
    end else begin
      r_seg         <= w_seg_next ^ {7{SEG_ACTIVE_LOW}};
      r_dp_out      <= w_dp_next ^ SEG_ACTIVE_LOW;
      r_digit_en    <= w_en_next ^ {DIGITS{DIG_ACTIVE_LOW}};
      r_frame_start <= w_commit;
    end
  end

  assign bus.seg         = r_seg;
  assign bus.dp_out      = r_dp_out;
  assign bus.digit_en    = r_digit_en;
  assign bus.frame_start = r_frame_start;
  assign bus.pending     = r_pending;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: DIGITS=4, ON=4, BLANK=1 (20-cycle frame).
// Output cycle position pos=0 is the cycle frame_start is high; pos%5==0 are gaps.
module tb_seg7_scan_driver;

  localparam logic [6:0] TB_TBL [0:15] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1100111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   pos   = 0;
  logic [13:0] got, want;

  seg7_scan_driver_if #(.DIGITS(4)) bus1 ();
  seg7_scan_driver_if #(.DIGITS(4)) bus2 ();

  seg7_scan_driver #(
    .DIGITS(4), .ON_CYCLES(4), .BLANK_CYCLES(1),
    .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
  ) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  seg7_scan_driver #(
    .DIGITS(4), .ON_CYCLES(4), .BLANK_CYCLES(1),
    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {dp_out, seg, digit_en} (active-high) at frame position p.
  function automatic logic [11:0] model(int p, logic [15:0] v, logic [3:0] d, logic lz);
    logic [11:0] r;
    logic        zr;
    logic [3:0]  nib;
    int          k;
    r = '0;
    if (p % 5 != 0) begin
      k  = p / 5;
      zr = lz && (k != 0);
      for (int j = 3; j >= k; j--)
        if (v[4*j +: 4] != 4'h0 || d[j]) zr = 1'b0;
      if (!zr) begin
        nib = v[4*k +: 4];
        r   = {d[k], TB_TBL[nib], 4'(1 << k)};
      end
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    pos = (pos + 1) % 20;
  endtask

  task automatic sample1();
    got = {bus1.frame_start, bus1.pending, bus1.dp_out, bus1.seg, bus1.digit_en};
  endtask

  task automatic load1(logic [15:0] v, logic [3:0] d, logic lz);
    bus1.value = v; bus1.dp = d; bus1.lz_blank = lz; bus1.load = 1'b1;
    tick();
    bus1.load = 1'b0;
    $display("load value=%h dp=%b lz=%b now pos=%0d", v, d, lz, pos);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      sample1();
      want = '0;
      total++;
      if (got !== want) begin bad++; $display("FAIL reset1 c=%0d got=%b want=%b", c, got, want); end
      got  = {bus2.frame_start, bus2.pending, bus2.dp_out, bus2.seg, bus2.digit_en};
      want = {2'b00, 1'b1, 7'h7F, 4'hF};
      total++;
      if (got !== want) begin bad++; $display("FAIL reset2 c=%0d got=%b want=%b", c, got, want); end
    end
    reset = 1'b0;
    tick();
    pos = 0;
    $display("reset released");
  endtask

  task automatic test_scan();
    for (int c = 0; c < 25; c++) begin
      if (c > 0) tick();
      sample1();
      want = {pos == 0, 1'b0, model(pos, 16'h0000, 4'h0, 1'b0)};
      total++;
      if (got !== want) begin bad++; $display("FAIL scan c=%0d got=%b want=%b", c, got, want); end
    end
    $display("scan idle frame checked");
  endtask

  task automatic test_load();
    load1(16'h12AF, 4'h0, 1'b0);
    while (pos != 0) begin
      sample1();
      want = {1'b0, 1'b1, model(pos, 16'h0000, 4'h0, 1'b0)};
      total++;
      if (got !== want) begin bad++; $display("FAIL load_pend pos=%0d got=%b want=%b", pos, got, want); end
      tick();
    end
    for (int c = 0; c < 20; c++) begin
      sample1();
      want = {pos == 0, 1'b0, model(pos, 16'h12AF, 4'h0, 1'b0)};
      total++;
      if (got !== want) begin bad++; $display("FAIL load_show pos=%0d got=%b want=%b", pos, got, want); end
      tick();
    end
    $display("load 12AF frame checked");
  endtask

  task automatic test_back_to_back();
    load1(16'h1111, 4'h0, 1'b0);
    while (pos != 6) begin
      sample1();
      want = {1'b0, 1'b1, model(pos, 16'h12AF, 4'h0, 1'b0)};
      total++;
      if (got !== want) begin bad++; $display("FAIL b2b_first pos=%0d got=%b want=%b", pos, got, want); end
      tick();
    end
    load1(16'h2222, 4'h0, 1'b0);
    while (pos != 0) begin
      sample1();
      want = {1'b0, 1'b1, model(pos, 16'h12AF, 4'h0, 1'b0)};
      total++;
      if (got !== want) begin bad++; $display("FAIL b2b_pend pos=%0d got=%b want=%b", pos, got, want); end
      tick();
    end
    for (int c = 0; c < 20; c++) begin
      sample1();
      want = {pos == 0, 1'b0, model(pos, 16'h2222, 4'h0, 1'b0)};
      total++;
      if (got !== want) begin bad++; $display("FAIL b2b_show pos=%0d got=%b want=%b", pos, got, want); end
      tick();
    end
    $display("back-to-back loads checked");
  endtask

  task automatic test_lz_blank();
    load1(16'h0005, 4'b0000, 1'b1);
    while (pos != 0) begin
      sample1();
      want = {1'b0, 1'b1, model(pos, 16'h2222, 4'h0, 1'b0)};
      total++;
      if (got !== want) begin bad++; $display("FAIL lz_pend pos=%0d got=%b want=%b", pos, got, want); end
      tick();
    end
    for (int c = 0; c < 20; c++) begin
      sample1();
      want = {pos == 0, 1'b0, model(pos, 16'h0005, 4'b0000, 1'b1)};
      total++;
      if (got !== want) begin bad++; $display("FAIL lz_nodp pos=%0d got=%b want=%b", pos, got, want); end
      tick();
    end
    load1(16'h0005, 4'b0100, 1'b1);
    while (pos != 0) begin
      sample1();
      want = {1'b0, 1'b1, model(pos, 16'h0005, 4'b0000, 1'b1)};
      total++;
      if (got !== want) begin bad++; $display("FAIL lz_pend2 pos=%0d got=%b want=%b", pos, got, want); end
      tick();
    end
    for (int c = 0; c < 20; c++) begin
      sample1();
      want = {pos == 0, 1'b0, model(pos, 16'h0005, 4'b0100, 1'b1)};
      total++;
      if (got !== want) begin bad++; $display("FAIL lz_dp pos=%0d got=%b want=%b", pos, got, want); end
      tick();
    end
    $display("leading-zero blanking checked");
  endtask

  task automatic test_commit_load();
    while (pos != 19) tick();
    load1(16'hBEEF, 4'b0000, 1'b0);
    for (int c = 0; c < 20; c++) begin
      sample1();
      want = {pos == 0, 1'b0, model(pos, 16'hBEEF, 4'b0000, 1'b0)};
      total++;
      if (got !== want) begin bad++; $display("FAIL commit_load pos=%0d got=%b want=%b", pos, got, want); end
      tick();
    end
    while (pos != 12) tick();
    reset = 1'b1;
    tick();
    sample1();
    want = '0;
    total++;
    if (got !== want) begin bad++; $display("FAIL midscan_reset got=%b want=%b", got, want); end
    reset = 1'b0;
    tick();
    pos = 0;
    for (int c = 0; c < 20; c++) begin
      sample1();
      want = {pos == 0, 1'b0, model(pos, 16'h0000, 4'b0000, 1'b0)};
      total++;
      if (got !== want) begin bad++; $display("FAIL restart pos=%0d got=%b want=%b", pos, got, want); end
      tick();
    end
    $display("commit-cycle load and mid-scan reset checked");
  endtask

  task automatic test_polarity();
    logic [11:0] m;
    for (int c = 0; c < 20; c++) begin
      got  = {bus2.frame_start, bus2.pending, bus2.dp_out, bus2.seg, bus2.digit_en};
      m    = model(pos, 16'h0000, 4'b0000, 1'b0);
      want = {pos == 0, 1'b0, ~m};
      total++;
      if (got !== want) begin bad++; $display("FAIL polarity pos=%0d got=%b want=%b", pos, got, want); end
      tick();
    end
    $display("active-low polarity checked");
  endtask

  initial begin
    reset          = 1'b1;
    bus1.value     = '0; bus1.dp = '0; bus1.lz_blank = 1'b0; bus1.load = 1'b0;
    bus2.value     = '0; bus2.dp = '0; bus2.lz_blank = 1'b0; bus2.load = 1'b0;
    test_reset();
    test_scan();
    test_load();
    test_back_to_back();
    test_lz_blank();
    test_commit_load();
    test_polarity();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Time-multiplexed driver for a DIGITS-wide common-anode/common-cathode 7-segment display bank.
- Accepts a packed hex value through a load strobe and double-buffers it.
- Commits the buffered value only at frame boundaries, so a frame never shows a mix of old and new digits.
- Scans one digit at a time, with a dead-time gap between digits to suppress ghosting.
- Sits between arithmetic/counter logic and the board pins; it supersedes the single-digit static decoder.

Parameters:
DIGITS, 4, number of digits scanned (1..8); digit 0 is least significant.
ON_CYCLES, 4000, clk cycles each digit is driven (>=1).
BLANK_CYCLES, 40, dead-time cycles before each digit, all digits off (>=1).
SEG_ACTIVE_LOW, 0, 1 inverts seg and dp_out.
DIG_ACTIVE_LOW, 0, 1 inverts digit_en.

Ports:
clk  in  1  system clock; the only clock.
reset  in  1  synchronous, active-high reset.
value  in  4*DIGITS  hex nibbles; [3:0] is digit 0.
dp  in  DIGITS  decimal point per digit; sampled together with value.
lz_blank  in  1  leading-zero blanking enable; sampled together with value.
load  in  1  one-cycle strobe; captures value/dp/lz_blank into the shadow register.
pending  out  1  shadow holds data not yet committed.
frame_start  out  1  one-cycle pulse on the cycle a commit point occurs.
seg  out  7  segments {G,F,E,D,C,B,A}.
dp_out  out  1  decimal-point segment.
digit_en  out  DIGITS  one-hot digit enable.

Behaviour:
- All outputs are registered.
- Reset values:
  - seg, dp_out and digit_en inactive (polarity applied).
  - pending=0, frame_start=0.
  - Shadow and active registers = 0; lz_blank copies = 0.
  - Digit index = 0; FSM = BLANK; cycle counter = 0.
- Reset mid-scan: takes effect on the next edge and aborts the current slot immediately.
- FSM has two states:
  - BLANK: all digit_en inactive. Runs BLANK_CYCLES cycles, then goes to ON.
  - ON: digit_en[idx] active, seg/dp_out driven for idx. Runs ON_CYCLES cycles, then goes to BLANK and idx advances.
- idx wraps from DIGITS-1 to 0. Frame period = DIGITS*(ON_CYCLES+BLANK_CYCLES) cycles.
- Commit point: the first BLANK cycle of digit 0, including the first BLANK after reset.
  - If pending=1: active <= shadow, pending <= 0.
  - frame_start pulses on every commit point, whether or not a commit happens.
- load:
  - shadow <= inputs; pending <= 1 on the next cycle.
  - A repeated load before the commit point overwrites the shadow; the last load wins.
- load in the same cycle as a commit point: the incoming data goes straight to active and pending stays 0.
- Decode table (nibble -> {G..A}):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1100111, A=1110111, b=1111100
  - C=0111001, d=1011110, E=1111001, F=1110001
- Leading-zero blanking, evaluated on the active register:
  - Digit k is blanked when lz_blank=1, k>0, and every nibble from DIGITS-1 down to k is 0 with dp=0.
  - A set dp terminates the zero run.
  - Digit 0 is never blanked.
  - A blanked digit keeps digit_en inactive for its whole ON slot; timing is unchanged.
- dp_out = dp[idx] during ON for an unblanked digit, otherwise inactive.
- Polarity is applied only at the output registers; internal logic is active-high.
- DIGITS=1: the commit point occurs every ON_CYCLES+BLANK_CYCLES cycles.

Decomposition:
- Package seg7_pkg holds:
  - segment bit-index constants (A=0..G=6);
  - the 16-entry hex decode constant table;
  - the FSM state encoding (BLANK=0, ON=1).
- One sub-module, hex_to_seg7: a combinational nibble-to-segment decoder using the package table.
- The scan FSM, counters, double buffer and blanking logic stay in seg7_scan_driver.

Test Plan:
All scenarios use DIGITS=4, ON_CYCLES=4, BLANK_CYCLES=1 (frame period 20 cycles) unless stated.
1. Reset, then hold 25 cycles. Required:
   - frame_start at cycles 0 and 20.
   - digit_en = 0001,0010,0100,1000, each for 4 cycles, separated by 1-cycle 0000 gaps.
   - seg = 0111111 throughout ON.
2. load value=16'h12AF, lz_blank=0. Required:
   - pending=1 until the next commit point.
   - From that frame: digit0 seg=1110001, digit1=1110111, digit2=1011011, digit3=0000110.
3. Load 16'h1111 then 16'h2222 within one frame. Required: after commit all digits show 1011011; 1111 is never displayed.
4. value=16'h0005, dp=4'b0000, lz_blank=1. Required:
   - digit_en pulses only for digit 0 (seg=1101101); slots 1-3 stay 0000.
   - Then dp=4'b0100: digits 0-2 shown (digit2 with dp_out active); digit3 blanked.
5. load exactly on a commit cycle. Required: the new value is shown in that frame and pending never rises.
   - Also: assert reset during digit2 ON. Required: outputs inactive next cycle, active=0, and the scan restarts at digit 0.
6. SEG_ACTIVE_LOW=1, DIG_ACTIVE_LOW=1, value=0. Required: seg=1000000 and digit_en active-low one-hot (e.g. 1110); idle gaps read 1111.
